// File: rtl/mem_acc_port_arbiter_if.sv
// Purpose: memory-access bus bundle shared by the DMA engine, the SIMD ldst unit
//          and mem_acc_cont.
// Ports (as signals):
//   write_valid/write_address/write_data  requester -> memory   posted write
//   write_ready                           memory -> requester   write accepted
//   read_valid/read_address               requester -> memory   read request
//   read_ready                            memory -> requester   read accepted
//   read_pause                            requester -> memory   hold off returning data
//   read_data_valid/read_data             memory -> requester   returning read data
// Modports: master = requester side, slave = memory side.
interface mem_acc_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              write_valid;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_ready;
  logic              read_valid;
  logic [ADDR_W-1:0] read_address;
  logic              read_ready;
  logic              read_pause;
  logic              read_data_valid;
  logic [DATA_W-1:0] read_data;

  modport master (
    output write_valid, write_address, write_data,
    output read_valid, read_address, read_pause,
    input  write_ready, read_ready, read_data_valid, read_data
  );

  modport slave (
    input  write_valid, write_address, write_data,
    input  read_valid, read_address, read_pause,
    output write_ready, read_ready, read_data_valid, read_data
  );
endinterface

// File: rtl/mem_acc_port_arbiter.sv
// Purpose: shares the single mem_acc_cont access port between the PE DMA engine
//          (default owner) and the SIMD load/store unit. In-flight reads are drained
//          before every ownership change so read data always returns to its issuer.
// Ports:
//   clk                   in   single clock, posedge
//   reset_poweron_n       in   asynchronous active-low reset
//   dma                   slave  DMA request bus (dma__memc__* / memc__dma__*)
//   ldst                  slave  ldst request bus (ldst__memc__* / memc__ldst__*)
//   mem                   master bus to mem_acc_cont (arb__mem__* / mem__arb__*)
//   ldst__memc__request   in   ldst ownership request (level)
//   ldst__memc__released  in   ldst release pulse
//   memc__ldst__granted   out  registered, high while ldst owns the port
module mem_acc_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   reset_poweron_n,
  mem_acc_port_arbiter_if.slave  dma,
  mem_acc_port_arbiter_if.slave  ldst,
  mem_acc_port_arbiter_if.master mem,
  input  logic                   ldst__memc__request,
  input  logic                   ldst__memc__released,
  output logic                   memc__ldst__granted
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    DMA_OWN,
    DRAIN_TO_LDST,
    LDST_OWN,
    DRAIN_TO_DMA
  } state_e;

  state_e             state_q, state_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               granted_q;

  logic              own_dma;
  logic              own_ldst;
  logic              data_to_dma;
  logic              read_sat;
  logic              rd_valid;
  logic              rd_issue;
  logic              rd_return;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_data;

  assign memc__ldst__granted = granted_q;

  // State, outstanding-read counter and grant flag
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q   <= DMA_OWN;
      outst_q   <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      granted_q <= (state_d == LDST_OWN);
    end
  end

  // Next state, counter update and combinational bus routing
  always_comb begin
    state_d   = state_q;
    outst_d   = outst_q;
    wr_addr   = '0;
    rd_addr   = '0;
    wr_data   = '0;
    rd_valid  = 1'b0;

    mem.write_valid     = 1'b0;
    mem.write_address   = '0;
    mem.write_data      = '0;
    mem.read_valid      = 1'b0;
    mem.read_address    = '0;
    mem.read_pause      = 1'b0;
    dma.write_ready     = 1'b0;
    dma.read_ready      = 1'b0;
    dma.read_data_valid = 1'b0;
    dma.read_data       = '0;
    ldst.write_ready     = 1'b0;
    ldst.read_ready      = 1'b0;
    ldst.read_data_valid = 1'b0;
    ldst.read_data       = '0;

    // A pending ldst request blocks DMA issue at once so no new read can slip
    // in behind the drain.
    own_dma     = (state_q == DMA_OWN) && !ldst__memc__request;
    own_ldst    = (state_q == LDST_OWN);
    data_to_dma = (state_q == DMA_OWN) || (state_q == DRAIN_TO_LDST);
    read_sat    = (outst_q == OUTST_W'(MAX_OUTST));

    if (own_dma) begin
      mem.write_valid = dma.write_valid;
      wr_addr         = dma.write_address;
      wr_data         = dma.write_data;
      rd_valid        = dma.read_valid & ~read_sat;
      rd_addr         = dma.read_address;
      dma.write_ready = mem.write_ready;
      dma.read_ready  = mem.read_ready & ~read_sat;
    end else if (own_ldst) begin
      mem.write_valid  = ldst.write_valid;
      wr_addr          = ldst.write_address;
      wr_data          = ldst.write_data;
      rd_valid         = ldst.read_valid & ~read_sat;
      rd_addr          = ldst.read_address;
      ldst.write_ready = mem.write_ready;
      ldst.read_ready  = mem.read_ready & ~read_sat;
    end

    mem.write_address = wr_addr;
    mem.write_data    = wr_data;
    mem.read_valid    = rd_valid;
    mem.read_address  = rd_addr;

    // Returning data (and its pause) belongs to whoever issued the reads
    if (data_to_dma) begin
      mem.read_pause      = dma.read_pause;
      dma.read_data_valid = mem.read_data_valid;
      dma.read_data       = mem.read_data;
    end else begin
      mem.read_pause       = ldst.read_pause;
      ldst.read_data_valid = mem.read_data_valid;
      ldst.read_data       = mem.read_data;
    end

    // Stray data at zero outstanding is ignored so the counter never wraps
    rd_issue  = rd_valid & mem.read_ready;
    rd_return = mem.read_data_valid & (outst_q != '0);
    if (rd_issue && !rd_return) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (!rd_issue && rd_return) begin
      outst_d = outst_q - OUTST_W'(1);
    end

    // Drain completes on the edge that retires the last read
    unique case (state_q)
      DMA_OWN: begin
        if (ldst__memc__request) state_d = DRAIN_TO_LDST;
      end
      DRAIN_TO_LDST: begin
        if (!ldst__memc__request)   state_d = DMA_OWN;
        else if (outst_d == '0)     state_d = LDST_OWN;
      end
      LDST_OWN: begin
        if (ldst__memc__released) state_d = DRAIN_TO_DMA;
      end
      DRAIN_TO_DMA: begin
        if (outst_d == '0) state_d = DMA_OWN;
      end
    endcase
  end

  // Simulation-only flag for read data nobody asked for
  always @(posedge clk) begin
    if (reset_poweron_n && mem.read_data_valid && (outst_q == '0)) begin
      $error("mem_acc_port_arbiter: read_data_valid with no read outstanding");
    end
  end

endmodule

// File: tb/tb_mem_acc_port_arbiter.sv
// Purpose: self-checking bench for mem_acc_port_arbiter: a directed vector table
//          for ownership hand-over, plus sequences for read saturation and
//          asynchronous reset in the middle of ldst ownership.
module tb_mem_acc_port_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic reset_poweron_n;
  logic req;
  logic rel;
  logic granted;

  int checks;
  int errors;

  mem_acc_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dma_if (), ldst_if (), mem_if ();

  mem_acc_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_OUTST(4)
  ) dut (
    .clk                 (clk),
    .reset_poweron_n     (reset_poweron_n),
    .dma                 (dma_if),
    .ldst                (ldst_if),
    .mem                 (mem_if),
    .ldst__memc__request (req),
    .ldst__memc__released(rel),
    .memc__ldst__granted (granted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {mem_wv, mem_rv, mem_pause, dma_wr, dma_rr, dma_dv, ldst_wr, ldst_rr, ldst_dv, granted}
  typedef struct {
    logic        req;
    logic        rel;
    logic        dwv;
    logic        drv;
    logic [15:0] da;
    logic        lwv;
    logic        lrv;
    logic [15:0] la;
    logic        mdv;
    logic [31:0] rdata;
    logic [9:0]  flags;
    logic        dside;
    logic [15:0] addr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rl, input logic dwv, input logic drv,
                              input logic [15:0] da, input logic lwv, input logic lrv,
                              input logic [15:0] la, input logic mdv, input logic [31:0] rdata,
                              input logic [9:0] flags, input logic dside,
                              input logic [15:0] addr, input logic [31:0] wd);
    vec_t v;
    v.req = r; v.rel = rl; v.dwv = dwv; v.drv = drv; v.da = da;
    v.lwv = lwv; v.lrv = lrv; v.la = la; v.mdv = mdv; v.rdata = rdata;
    v.flags = flags; v.dside = dside; v.addr = addr; v.wd = wd;
    return v;
  endfunction

  function automatic logic [9:0] flags_now();
    return {mem_if.write_valid, mem_if.read_valid, mem_if.read_pause,
            dma_if.write_ready, dma_if.read_ready, dma_if.read_data_valid,
            ldst_if.write_ready, ldst_if.read_ready, ldst_if.read_data_valid, granted};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req                   = v.req;
    rel                   = v.rel;
    dma_if.write_valid    = v.dwv;
    dma_if.write_address  = v.da;
    dma_if.read_valid     = v.drv;
    dma_if.read_address   = v.da;
    ldst_if.write_valid   = v.lwv;
    ldst_if.write_address = v.la;
    ldst_if.read_valid    = v.lrv;
    ldst_if.read_address  = v.la;
    mem_if.read_data_valid = v.mdv;
    mem_if.read_data       = v.rdata;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 32'h0, 10'b0, 1'b1, 16'h0, 32'h0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_poweron_n = 1'b0;
    idle();
    dma_if.write_data   = '0;
    dma_if.read_pause   = 1'b0;
    ldst_if.write_data  = '0;
    ldst_if.read_pause  = 1'b0;
    mem_if.write_ready  = 1'b0;
    mem_if.read_ready   = 1'b0;

    // Reset with all inputs low: every output is zero
    #3;
    check("reset flags", 64'(flags_now()), 64'(0));
    check("reset mem addr/data", 64'({mem_if.write_address, mem_if.read_address, mem_if.write_data}), 64'(0));
    check("reset read data", 64'({dma_if.read_data, ldst_if.read_data}), 64'(0));

    @(negedge clk);
    reset_poweron_n     = 1'b1;
    mem_if.write_ready  = 1'b1;
    mem_if.read_ready   = 1'b1;
    dma_if.write_data   = 32'h0000_D000;
    ldst_if.write_data  = 32'h0000_00A5;
    ldst_if.read_pause  = 1'b1;

    // DMA reads 0x10..0x12 and their data return to DMA
    vecs.push_back(mk(0,0,0,1,16'h10,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h10,32'h0));
    vecs.push_back(mk(0,0,0,1,16'h11,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h11,32'h0));
    vecs.push_back(mk(0,0,0,1,16'h12,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h12,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,1,32'h1111_0001,10'b0001110000,1,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,1,32'h1111_0002,10'b0001110000,1,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,1,32'h1111_0003,10'b0001110000,1,16'h0,32'h0));
    // Two DMA reads in flight, then ldst requests; grant follows the last data
    vecs.push_back(mk(0,0,0,1,16'h20,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h20,32'h0));
    vecs.push_back(mk(0,0,0,1,16'h21,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h21,32'h0));
    vecs.push_back(mk(1,0,1,0,16'h30,1,1,16'h31,0,32'h0,       10'b0000000000,1,16'h0,32'h0));
    vecs.push_back(mk(1,0,0,0,16'h0, 1,1,16'h31,1,32'h2222_0001,10'b0000010000,1,16'h0,32'h0));
    vecs.push_back(mk(1,0,0,0,16'h0, 1,1,16'h31,1,32'h2222_0002,10'b0000010000,1,16'h0,32'h0));
    // ldst owns: write 0xA5 to 0x40, one read round trip, then release
    vecs.push_back(mk(1,0,1,0,16'h41,1,0,16'h40,0,32'h0,       10'b1010001101,0,16'h40,32'hA5));
    vecs.push_back(mk(1,0,0,0,16'h0, 0,1,16'h44,0,32'h0,       10'b0110001101,0,16'h44,32'h0));
    vecs.push_back(mk(1,0,0,0,16'h0, 0,0,16'h0,1,32'h4444_0001,10'b0010001111,0,16'h0,32'h0));
    vecs.push_back(mk(0,1,1,0,16'h41,0,0,16'h40,0,32'h0,       10'b0010001101,0,16'h0,32'h0));
    vecs.push_back(mk(0,0,1,0,16'h41,0,0,16'h0,0,32'h0,        10'b0010000000,0,16'h0,32'h0));
    vecs.push_back(mk(0,0,1,0,16'h41,0,0,16'h0,0,32'h0,        10'b1001100000,1,16'h41,32'hD000));
    // Request dropped during drain: abort, never granted
    vecs.push_back(mk(0,0,0,1,16'h50,0,0,16'h0,0,32'h0,        10'b0101100000,1,16'h50,32'h0));
    vecs.push_back(mk(1,0,0,0,16'h0, 0,0,16'h0,0,32'h0,        10'b0000000000,1,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,0,32'h0,        10'b0000000000,1,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,1,32'h5555_0001,10'b0001110000,1,16'h0,32'h0));
    // Release outside LDST_OWN is ignored
    vecs.push_back(mk(0,1,0,0,16'h0, 0,0,16'h0,0,32'h0,        10'b0001100000,1,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,16'h0, 0,0,16'h0,0,32'h0,        10'b0001100000,1,16'h0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d flags", i), 64'(flags_now()), 64'(vecs[i].flags));
      check($sformatf("v%0d dma rdata", i), 64'(dma_if.read_data),
            64'(vecs[i].dside ? vecs[i].rdata : 32'h0));
      check($sformatf("v%0d ldst rdata", i), 64'(ldst_if.read_data),
            64'(vecs[i].dside ? 32'h0 : vecs[i].rdata));
      if (vecs[i].flags[9]) begin
        check($sformatf("v%0d wr addr", i), 64'(mem_if.write_address), 64'(vecs[i].addr));
        check($sformatf("v%0d wr data", i), 64'(mem_if.write_data), 64'(vecs[i].wd));
      end
      if (vecs[i].flags[8]) begin
        check($sformatf("v%0d rd addr", i), 64'(mem_if.read_address), 64'(vecs[i].addr));
      end
    end

    // Saturation: four reads accepted, fifth held off until data returns
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      dma_if.read_valid   = 1'b1;
      dma_if.read_address = 16'(16'h70 + i);
      #1;
      check($sformatf("sat read%0d ready", i), 64'(dma_if.read_ready), 64'(1));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("sat full%0d ready", i), 64'(dma_if.read_ready), 64'(0));
      check($sformatf("sat full%0d mem valid", i), 64'(mem_if.read_valid), 64'(0));
    end
    @(negedge clk);
    mem_if.read_data_valid = 1'b1;
    mem_if.read_data       = 32'h7777_0001;
    @(negedge clk);
    mem_if.read_data_valid = 1'b0;
    #1;
    check("sat after data ready", 64'(dma_if.read_ready), 64'(1));
    check("sat after data mem valid", 64'(mem_if.read_valid), 64'(1));
    @(negedge clk);
    dma_if.read_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.read_data_valid = 1'b1;
      mem_if.read_data       = 32'(32'h7777_0010 + i);
      @(negedge clk);
    end
    idle();
    req = 1'b1;
    @(negedge clk);
    #1;
    check("sat drained grant edge1", 64'(granted), 64'(0));
    @(negedge clk);
    #1;
    check("sat drained grant edge2", 64'(granted), 64'(1));

    // Async reset while ldst owns with two reads in flight
    @(negedge clk);
    req = 1'b0;
    ldst_if.read_valid   = 1'b1;
    ldst_if.read_address = 16'h80;
    @(negedge clk);
    ldst_if.read_address = 16'h81;
    @(negedge clk);
    ldst_if.read_valid   = 1'b0;
    dma_if.write_valid   = 1'b1;
    dma_if.write_address = 16'h90;
    #1;
    check("rst pre granted", 64'(granted), 64'(1));
    check("rst pre dma wr ready", 64'(dma_if.write_ready), 64'(0));
    #1;
    reset_poweron_n = 1'b0;
    #1;
    check("rst async granted", 64'(granted), 64'(0));
    check("rst async dma pass", 64'({mem_if.write_valid, dma_if.write_ready, ldst_if.write_ready}),
          64'(3'b110));
    check("rst async wr addr", 64'(mem_if.write_address), 64'(16'h90));
    @(negedge clk);
    reset_poweron_n    = 1'b1;
    dma_if.write_valid = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst outst cleared grant", 64'(granted), 64'(1));
    @(negedge clk);
    req = 1'b0;
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    #1;
    check("rel granted low", 64'(granted), 64'(0));
    @(negedge clk);
    #1;
    check("rel back to dma", 64'({dma_if.write_ready, ldst_if.write_ready}), 64'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
